serial_pair_adder_ctrl: RTL

Sequencer that adds two WIDTH-bit operands two bits per clock, using an internal 2-bit parallel adder slice with a registered carry between slices. It time-shares one small 2-bit adder datapath across a wider word instead of building a full-width ripple adder. It uses a start/busy/done handshake. The result and carry-out are held stable in output registers between operations.

---
 rtl/serial_pair_adder_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/serial_pair_adder_ctrl.sv
// serial_pair_adder_ctrl
//
// Adds two WIDTH-bit unsigned operands two bits per clock. A single 2-bit
// adder slice is time-shared across the word, and a registered carry links
// consecutive slices. The block uses a start/busy/done handshake. The final
// sum and carry-out sit in output registers that change only when an
// operation completes.
//
// Ports:
//   clk   - system clock, rising-edge active
//   rst   - asynchronous, active-high reset
//   start - request an addition (sampled only while idle)
//   a, b  - operands, captured on the edge that accepts start
//   busy  - high while slices are being processed
//   done  - one-cycle pulse when sum/co have just been updated
//   sum   - registered result, (a+b) mod 2^WIDTH
//   co    - registered carry-out of the full-width addition
module serial_pair_adder_ctrl #(
  parameter int WIDTH = 8  // even, >= 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int SLICES = WIDTH / 2;
  // Keep the counter at least one bit wide so that WIDTH=2 still elaborates.
  localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] acc_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             co_reg;

  // The 2-bit adder slice that is shared by every bit pair.
  logic [2:0]       slice_sum;
  logic [WIDTH-1:0] acc_next;
  logic             last_slice;

  assign slice_sum  = {1'b0, a_sh_reg[1:0]} + {1'b0, b_sh_reg[1:0]} + {2'b00, carry_reg};
  assign last_slice = (cnt_reg == CNT_W'(SLICES - 1));

  // Merge this cycle's slice into the accumulator at bit pair cnt. The merged
  // value also feeds sum directly on the final edge, so the last slice does
  // not have to wait an extra cycle in acc_reg.
  for (genvar gi = 0; gi < SLICES; gi++) begin : g_acc
    assign acc_next[2*gi +: 2] = (cnt_reg == CNT_W'(gi)) ? slice_sum[1:0]
                                                          : acc_reg[2*gi +: 2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      co_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= a;
            b_sh_reg  <= b;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          carry_reg <= slice_sum[2];
          a_sh_reg  <= a_sh_reg >> 2;
          b_sh_reg  <= b_sh_reg >> 2;
          cnt_reg   <= cnt_reg + 1'b1;
          if (last_slice) begin
            sum_reg   <= acc_next;
            co_reg    <= slice_sum[2];
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign sum  = sum_reg;
  assign co   = co_reg;

endmodule
